// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
package matmul_pkg;

  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_RES = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_e;

  // Flat element index of (r,c) in a row-major n x n matrix.
  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matmul_vec_select.sv
// Combinational extraction of row i of A and column j of B from the latched matrices.
module matmul_vec_select import matmul_pkg::*; #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N*N*WORD_WIDTH-1:0] i_mat_a,
  input  logic [N*N*WORD_WIDTH-1:0] i_mat_b,
  input  logic [IdxW-1:0]           i_row_idx,
  input  logic [IdxW-1:0]           i_col_idx,
  output logic [N*WORD_WIDTH-1:0]   o_row,
  output logic [N*WORD_WIDTH-1:0]   o_column
);

  // Gather A(i,k) and B(k,j) for every k.
  always_comb begin
    o_row    = '0;
    o_column = '0;
    for (int unsigned k = 0; k < N; k++) begin
      o_row[WORD_WIDTH*k +: WORD_WIDTH] =
          i_mat_a[WORD_WIDTH*elem_idx(32'(i_row_idx), k, N) +: WORD_WIDTH];
      o_column[WORD_WIDTH*k +: WORD_WIDTH] =
          i_mat_b[WORD_WIDTH*elem_idx(k, 32'(i_col_idx), N) +: WORD_WIDTH];
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences an N x N single-precision matrix product through an attached inner_product
// unit, one result element at a time in row-major order.
// Optional watchdog on the handshake waits: define MATMUL_SEQ_TIMEOUT_EN.
module matmul_sequencer import matmul_pkg::*; #(
  parameter int unsigned N = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N*N*WORD_WIDTH-1:0] mat_a,
  input  logic [N*N*WORD_WIDTH-1:0] mat_b,
  output logic                      busy,
  output logic                      done,
  output logic [N*N*WORD_WIDTH-1:0] mat_c,
  output logic [N*WORD_WIDTH-1:0]   ip_row,
  output logic [N*WORD_WIDTH-1:0]   ip_column,
  output logic                      ip_row_stb,
  output logic                      ip_column_stb,
  output logic                      ip_out_ack,
  input  logic                      ip_row_ack,
  input  logic                      ip_column_ack,
  input  logic [WORD_WIDTH-1:0]     ip_out,
  input  logic                      ip_out_stb
`ifdef MATMUL_SEQ_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam int unsigned    IdxW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  state_e                    r_state;
  logic [N*N*WORD_WIDTH-1:0] r_mat_a;
  logic [N*N*WORD_WIDTH-1:0] r_mat_b;
  logic [N*N*WORD_WIDTH-1:0] r_mat_c;
  logic [IdxW-1:0]           r_i;
  logic [IdxW-1:0]           r_j;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_stb;  // drives both stbs and ip_out_ack together
`ifdef MATMUL_SEQ_TIMEOUT_EN
  logic [15:0]               r_wdog;
  logic                      r_timeout;
`endif

  matmul_vec_select #(
    .N    (N),
    .IdxW (IdxW)
  ) u_vec_select (
    .i_mat_a   (r_mat_a),
    .i_mat_b   (r_mat_b),
    .i_row_idx (r_i),
    .i_col_idx (r_j),
    .o_row     (ip_row),
    .o_column  (ip_column)
  );

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_mat_a   <= '0;
      r_mat_b   <= '0;
      r_mat_c   <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stb     <= 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      r_wdog    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mat_a   <= mat_a;
            r_mat_b   <= mat_b;
            r_i       <= '0;
            r_j       <= '0;
            r_busy    <= 1'b1;
            r_state   <= ISSUE;
`ifdef MATMUL_SEQ_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          r_stb   <= 1'b1;
          r_state <= WAIT_ACK;
`ifdef MATMUL_SEQ_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        WAIT_ACK: begin
          if (ip_row_ack && ip_column_ack) begin
            r_stb   <= 1'b0;
            r_state <= WAIT_RES;
`ifdef MATMUL_SEQ_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end
`ifdef MATMUL_SEQ_TIMEOUT_EN
          else if (r_wdog == 16'hFFFF) begin
            r_stb     <= 1'b0;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
`endif
        end
        WAIT_RES: begin
          if (ip_out_stb) begin
            r_mat_c[WORD_WIDTH*elem_idx(32'(r_i), 32'(r_j), N) +: WORD_WIDTH] <= ip_out;
            r_state <= DRAIN;
          end
`ifdef MATMUL_SEQ_TIMEOUT_EN
          else if (r_wdog == 16'hFFFF) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
`endif
        end
        DRAIN: begin
          // The result strobe must fall before the next request can be issued.
          if (!ip_out_stb) begin
            if (r_j == LastIdx) begin
              if (r_i == LastIdx) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= DONE;
              end else begin
                r_j     <= '0;
                r_i     <= r_i + 1'b1;
                r_state <= ISSUE;
              end
            end else begin
              r_j     <= r_j + 1'b1;
              r_state <= ISSUE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_stb   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign mat_c         = r_mat_c;
  assign ip_row_stb    = r_stb;
  assign ip_column_stb = r_stb;
  assign ip_out_ack    = r_stb;
`ifdef MATMUL_SEQ_TIMEOUT_EN
  assign timeout_err   = r_timeout;
`endif

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Upstream controller for `inner_product`, one level up in the matrix multiplier.
- On `start`, latches square matrices A and B (N x N, IEEE-754 single, row-major flat buses).
- For every result element (i,j), presents row i of A and column j of B to `inner_product` through its stb/ack handshake, then captures the scalar result.
- Assembles C = A x B in a result register and signals `done`.

Parameters:
- `N`, 4, matrix dimension; also the `number_of_elements` of the attached `inner_product`; legal range 1..8.
- `WORD_WIDTH`, 32, element width; fixed at 32 (single precision).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a multiplication.
- `mat_a`  in  N*N*32  matrix A; element (r,c) at bits [32*(r*N+c) +: 32].
- `mat_b`  in  N*N*32  matrix B; same layout.
- `busy`  out  1  high from accepted start until `done`.
- `done`  out  1  one-cycle pulse when C is complete.
- `mat_c`  out  N*N*32  result matrix C; same layout; holds until the next accepted start.
- `ip_row`  out  N*32  row vector; element k at [32*k +: 32] = A(i,k).
- `ip_column`  out  N*32  column vector; element k at [32*k +: 32] = B(k,j).
- `ip_row_stb`  out  1  row valid.
- `ip_column_stb`  out  1  column valid.
- `ip_out_ack`  out  1  ready to accept result; asserted together with both stbs.
- `ip_row_ack`  in  1  row accepted.
- `ip_column_ack`  in  1  column accepted.
- `ip_out`  in  32  inner product result.
- `ip_out_stb`  in  1  result valid.

Behaviour:
- Reset when `rst`==0 at a rising edge: state=IDLE, `busy`=0, `done`=0, all `ip_*_stb`/`ip_out_ack`=0, `mat_c`=0, indices i=j=0.
  - Reset mid-operation aborts immediately; the partially built C is cleared.
- IDLE:
  - `start`=1 latches `mat_a`/`mat_b` into internal registers, sets i=j=0, `busy`=1, goes to ISSUE.
  - `start` while `busy` is ignored.
- ISSUE: drive `ip_row`/`ip_column` from the latched copies (stable until capture). Assert `ip_row_stb`, `ip_column_stb` and `ip_out_ack` in the same cycle. Go to WAIT_ACK.
- WAIT_ACK: hold all three high until `ip_row_ack` & `ip_column_ack`. Then deassert all three and go to WAIT_RES.
- WAIT_RES: on `ip_out_stb`=1, write `ip_out` into C(i,j) and go to DRAIN.
- DRAIN:
  - Wait until `ip_out_stb`=0. `inner_product` clears its stb only in idle with no pending request, so no new request may be issued before this.
  - Then advance row-major: j=j+1; at j=N-1 wrap j=0, i=i+1.
  - If (i,j) was (N-1,N-1), go to DONE; else go to ISSUE.
- DONE: `done`=1 for exactly one cycle, `busy`=0, go to IDLE.
  - `start` in the DONE cycle is ignored; it is accepted from IDLE only.
- Latency with zero-wait `inner_product` (ack/stb in the cycle after request): per element = ISSUE 1 + WAIT_ACK 1 + compute + 1 capture + DRAIN ≥1. Total = N*N*(per element) + 2 cycles start-to-done.
- Index counters are `$clog2(N)` bits, minimum width 1. For N=1, one element and no wrap.
- No arithmetic is performed here; `ip_out` is stored bit-exact, NaN/denormals included.

Optional Feature:
- Macro `MATMUL_SEQ_TIMEOUT_EN`.
- When defined:
  - Adds output `timeout_err` (1 bit, reset 0) and a 16-bit watchdog counter cleared on entry to WAIT_ACK/WAIT_RES and incremented each cycle spent there.
  - When the counter reaches 16'hFFFF: deassert all handshake outputs, set `timeout_err`=1 (sticky until reset or next accepted start), pulse `done`, return to IDLE. `mat_c` keeps the elements written so far.
- When undefined: no port, no counter; waits are unbounded.

Decomposition:
- Shared package `matmul_pkg`:
  - `WORD_WIDTH`=32.
  - State encoding localparams IDLE/ISSUE/WAIT_ACK/WAIT_RES/DRAIN/DONE.
  - Helper function `elem_idx(r,c,N)`.
- One natural sub-module `matmul_vec_select`: combinational extraction of row i / column j from the latched matrices. Everything else stays in the top.

Test Plan:
- Reset: hold `rst`=0 3 cycles, then 1 → `busy`=0, `done`=0, all stbs=0, `mat_c`=0.
- N=2, A=identity (3F800000 diag, 0 elsewhere), B={1.0,2.0,3.0,4.0} (3F800000,40000000,40400000,40800000); behavioural `inner_product` model → `mat_c`==B, single `done` pulse, 4 handshakes in order (0,0),(0,1),(1,0),(1,1).
- N=2, A=B=all 2.0 (40000000) → every C element 41000000 (8.0); `ip_column` for j=1 equals {B(1,1),B(0,1)}.
- Model delays ack by 5 cycles and holds `ip_out_stb` high 3 cycles → no duplicate capture, next ISSUE only after `ip_out_stb` low, C still correct.
- `start` pulsed again mid-run and in DONE cycle → ignored; `rst`=0 during element (1,0) → immediate IDLE, `mat_c`=0, stbs low next cycle.
- With `MATMUL_SEQ_TIMEOUT_EN`, model never acks → after 65535 cycles in WAIT_ACK, `timeout_err`=1, `done` pulse, stbs low.
